// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding selects, result-source codes
// and the shadow tag bundle tracked by the hazard unit.
package pipeline_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       isload;
  } hazard_tag_t;

  // True when tag t will write register rs (x0 never counts).
  function automatic logic tag_hits(
    input logic [4:0]  rs,
    input hazard_tag_t t
  );
    return t.regwrite && (t.rd != 5'd0) && (t.rd == rs);
  endfunction

  // Memory stage is the younger producer, so it wins over Writeback.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0]  rs,
    input hazard_tag_t m,
    input hazard_tag_t w
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if (tag_hits(rs, m))
      sel = FWD_MEM;
    else if (tag_hits(rs, w))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One shadow tag register: sync reset, flush loads a zero bubble.
// Ports: clk_i, rst_i, flush_i, tag_i (next tag), tag_o (held tag).
module hazard_tag_stage
  import pipeline_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  hazard_tag_t tag_i,
  output hazard_tag_t tag_o
);

  hazard_tag_t tag_q;
  hazard_tag_t tag_d;

  always_comb begin
    tag_d = tag_i;
    if (flush_i)
      tag_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      tag_q <= '0;
    else
      tag_q <= tag_d;
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forwarding selects, load-use stall, control flush
// and saturating stall/flush counters. Ports: Decode fields, PCSrc_E in;
// Stall_F/D, Flush_D/E, ForwardA/B_E, StallCnt, FlushCnt out.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rd_D,
  input  logic             RegWrite_D,
  input  logic [1:0]       ResultSrc_D,
  input  logic             PCSrc_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hazard_tag_t tag_dec;
  hazard_tag_t tag_e;
  hazard_tag_t tag_m;
  hazard_tag_t tag_w;

  logic lw;
  logic cf;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  always_comb begin
    tag_dec.rs1      = Rs1_D;
    tag_dec.rs2      = Rs2_D;
    tag_dec.rd       = Rd_D;
    tag_dec.regwrite = RegWrite_D;
    tag_dec.isload   = (ResultSrc_D == RESULTSRC_LOAD);
  end

  hazard_tag_stage u_tag_e (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (Flush_E),
    .tag_i   (tag_dec),
    .tag_o   (tag_e)
  );

  hazard_tag_stage u_tag_m (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (1'b0),
    .tag_i   (tag_e),
    .tag_o   (tag_m)
  );

  hazard_tag_stage u_tag_w (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (1'b0),
    .tag_i   (tag_m),
    .tag_o   (tag_w)
  );

  // Both source fields compared whatever the format: conservative stall.
  assign lw = tag_e.isload && (tag_e.rd != 5'd0) &&
              ((tag_e.rd == Rs1_D) || (tag_e.rd == Rs2_D));
  assign cf = PCSrc_E;

  // Flush beats stall; everything is held low during reset.
  always_comb begin
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Flush_D    = 1'b0;
    Flush_E    = 1'b0;
    ForwardA_E = FWD_NONE;
    ForwardB_E = FWD_NONE;
    if (!rst) begin
      Stall_F    = lw & ~cf;
      Stall_D    = lw & ~cf;
      Flush_D    = cf;
      Flush_E    = lw | cf;
      ForwardA_E = fwd_sel(tag_e.rs1, tag_m, tag_w);
      ForwardB_E = fwd_sel(tag_e.rs2, tag_m, tag_w);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall_D && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (Flush_D && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (CNT_W=4 so saturation is reachable).
// Directed scenarios plus a randomized run against an in-flight queue model.
module tb_hazard_unit;
  import pipeline_pkg::*;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1_d;
  logic [4:0]    rs2_d;
  logic [4:0]    rd_d;
  logic          rw_d;
  logic [1:0]    rsrc_d;
  logic          pc_e;
  logic          stall_f;
  logic          stall_d;
  logic          flush_d;
  logic          flush_e;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  hazard_unit #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1_D       (rs1_d),
    .Rs2_D       (rs2_d),
    .Rd_D        (rd_d),
    .RegWrite_D  (rw_d),
    .ResultSrc_D (rsrc_d),
    .PCSrc_E     (pc_e),
    .Stall_F     (stall_f),
    .Stall_D     (stall_d),
    .Flush_D     (flush_d),
    .Flush_E     (flush_e),
    .ForwardA_E  (fwd_a),
    .ForwardB_E  (fwd_b),
    .StallCnt    (stall_cnt),
    .FlushCnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue of issued instructions; last entry is in Execute,
  // the one before in Memory, the one before that in Writeback.
  typedef struct {
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit ld;
  } ins_t;

  ins_t pipe[$];
  int   m_stall;
  int   m_flush;
  int   checks;
  int   errors;

  function automatic ins_t bubble();
    ins_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.rw = 0; b.ld = 0;
    return b;
  endfunction

  function automatic ins_t decoded();
    ins_t d;
    d.rs1 = int'(rs1_d);
    d.rs2 = int'(rs2_d);
    d.rd  = int'(rd_d);
    d.rw  = rw_d;
    d.ld  = (rsrc_d == 2'b01);
    return d;
  endfunction

  // Nearest older instruction that writes r supplies the operand.
  function automatic logic [1:0] exp_fwd(input int r);
    ins_t p;
    for (int k = 1; k <= 2; k++) begin
      p = pipe[pipe.size() - 1 - k];
      if (r != 0 && p.rw && p.rd == r)
        return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit exp_lw();
    ins_t e;
    e = pipe[pipe.size() - 1];
    return e.ld && e.rd != 0 &&
           (e.rd == int'(rs1_d) || e.rd == int'(rs2_d));
  endfunction

  function automatic int sat(input int n);
    return (n > MAX) ? MAX : n;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(bubble());
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic drive(input int a, input int b, input int d,
                       input bit w, input logic [1:0] src,
                       input bit pc);
    rs1_d  = 5'(a);
    rs2_d  = 5'(b);
    rd_d   = 5'(d);
    rw_d   = w;
    rsrc_d = src;
    pc_e   = pc;
    #1;
  endtask

  task automatic advance();
    bit   lw;
    bit   cf;
    bit   r;
    ins_t d;
    lw = exp_lw();
    cf = pc_e;
    r  = rst;
    d  = decoded();
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (lw && !cf) m_stall++;
      if (cf) m_flush++;
      pipe.push_back((lw || cf) ? bubble() : d);
      if (pipe.size() > 3) void'(pipe.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic alu(input int d, input int a, input int b);
    drive(a, b, d, 1'b1, 2'b00, 1'b0);
    advance();
  endtask

  task automatic load(input int d, input int a);
    drive(a, 0, d, 1'b1, 2'b01, 1'b0);
    advance();
  endtask

  task automatic nop_issue();
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3, 4, 5, 1'b1, 2'b01, 1'b1);
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=00",
               {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b});
    end
    advance();
    advance();
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0",
               stall_cnt, flush_cnt);
    end
    rst = 1'b0;
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if ({stall_d, flush_e, fwd_a, fwd_b} !== 6'h00) begin
      errors++;
      $display("FAIL reset_empty got=%h want=00",
               {stall_d, flush_e, fwd_a, fwd_b});
    end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    alu(5, 1, 2);
    alu(6, 5, 3);
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_MEM || fwd_b !== FWD_NONE) begin
      errors++;
      $display("FAIL alu_fwd_mem got=%0d/%0d want=2/0", fwd_a, fwd_b);
    end
    advance();
    alu(5, 1, 2);
    nop_issue();
    alu(6, 5, 3);
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_WB || fwd_b !== FWD_NONE) begin
      errors++;
      $display("FAIL alu_fwd_wb got=%0d/%0d want=1/0", fwd_a, fwd_b);
    end
    checks++;
    if (stall_cnt !== 0) begin
      errors++;
      $display("FAIL alu_no_stall got=%0d want=0", stall_cnt);
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    load(7, 1);
    drive(7, 7, 8, 1'b1, 2'b00, 1'b0);
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
      errors++;
      $display("FAIL lu_stall got=%b want=1101",
               {stall_f, stall_d, flush_d, flush_e});
    end
    advance();
    drive(7, 7, 8, 1'b1, 2'b00, 1'b0);
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      errors++;
      $display("FAIL lu_release got=%b want=000",
               {stall_f, stall_d, flush_e});
    end
    advance();
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_WB || fwd_b !== FWD_WB) begin
      errors++;
      $display("FAIL lu_fwd got=%0d/%0d want=1/1", fwd_a, fwd_b);
    end
    checks++;
    if (stall_cnt !== 1) begin
      errors++;
      $display("FAIL lu_count got=%0d want=1", stall_cnt);
    end
    advance();
  endtask

  task automatic test_x0();
    do_reset();
    alu(0, 0, 0);
    alu(9, 0, 0);
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_NONE || fwd_b !== FWD_NONE) begin
      errors++;
      $display("FAIL x0_fwd got=%0d/%0d want=0/0", fwd_a, fwd_b);
    end
    advance();
    load(0, 1);
    drive(0, 0, 9, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall_d !== 1'b0 || flush_e !== 1'b0) begin
      errors++;
      $display("FAIL x0_stall got=%b%b want=00", stall_d, flush_e);
    end
    advance();
  endtask

  task automatic test_double_match();
    do_reset();
    alu(5, 1, 2);
    alu(5, 3, 4);
    alu(10, 5, 5);
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_MEM || fwd_b !== FWD_MEM) begin
      errors++;
      $display("FAIL double_fwd got=%0d/%0d want=2/2", fwd_a, fwd_b);
    end
    advance();
  endtask

  task automatic test_branch_lu();
    do_reset();
    load(7, 1);
    drive(7, 0, 9, 1'b1, 2'b01, 1'b1);
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      errors++;
      $display("FAIL br_lu got=%b want=0011",
               {stall_f, stall_d, flush_d, flush_e});
    end
    advance();
    drive(9, 9, 10, 1'b1, 2'b00, 1'b0);
    checks++;
    if (stall_d !== 1'b0) begin
      errors++;
      $display("FAIL br_bubble got=%b want=0", stall_d);
    end
    checks++;
    if (flush_cnt !== 1 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL br_counts got=%0d/%0d want=1/0",
               flush_cnt, stall_cnt);
    end
    advance();
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_NONE || fwd_b !== FWD_NONE) begin
      errors++;
      $display("FAIL br_discard got=%0d/%0d want=0/0", fwd_a, fwd_b);
    end
    advance();
  endtask

  task automatic test_mid_reset();
    do_reset();
    alu(5, 1, 2);
    alu(6, 5, 5);
    rst = 1'b1;
    drive(5, 6, 12, 1'b1, 2'b00, 1'b1);
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs got=%h want=00",
               {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b});
    end
    advance();
    rst = 1'b0;
    alu(12, 5, 6);
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_NONE || fwd_b !== FWD_NONE) begin
      errors++;
      $display("FAIL midrst_stale got=%0d/%0d want=0/0", fwd_a, fwd_b);
    end
    checks++;
    if (flush_cnt !== 0 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_counts got=%0d/%0d want=0/0",
               flush_cnt, stall_cnt);
    end
    advance();
    alu(11, 1, 2);
    alu(13, 11, 0);
    drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
    checks++;
    if (fwd_a !== FWD_MEM) begin
      errors++;
      $display("FAIL midrst_fresh got=%0d want=2", fwd_a);
    end
    advance();
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      load(7, 1);
      drive(7, 2, 8, 1'b1, 2'b00, 1'b0);
      advance();
      advance();
      want = (i + 1 > MAX) ? MAX : i + 1;
      checks++;
      if (stall_cnt !== CW'(want)) begin
        errors++;
        $display("FAIL sat_step%0d got=%0d want=%0d", i, stall_cnt, want);
      end
    end
    checks++;
    if (stall_cnt !== CW'(15)) begin
      errors++;
      $display("FAIL sat_final got=%0d want=15", stall_cnt);
    end
  endtask

  task automatic test_random();
    bit         lw;
    bit         cf;
    bit         ld;
    logic [1:0] src;
    logic [1:0] ea;
    logic [1:0] eb;
    logic [3:0] ctl;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      src = ld ? 2'b01 : 2'($urandom_range(0, 1) * 2 + $urandom_range(0, 1) * 3 % 4);
      if (src == 2'b01) src = 2'b11;
      if (ld) src = 2'b01;
      drive($urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)), src,
            ($urandom_range(0, 7) == 0));
      if (rst) begin
        ctl = 4'b0000;
        ea  = FWD_NONE;
        eb  = FWD_NONE;
      end else begin
        lw  = exp_lw();
        cf  = pc_e;
        ctl = {lw && !cf, lw && !cf, cf, lw || cf};
        ea  = exp_fwd(pipe[pipe.size() - 1].rs1);
        eb  = exp_fwd(pipe[pipe.size() - 1].rs2);
      end
      checks++;
      if ({stall_f, stall_d, flush_d, flush_e} !== ctl) begin
        errors++;
        $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", n,
                 {stall_f, stall_d, flush_d, flush_e}, ctl);
      end
      checks++;
      if (fwd_a !== ea || fwd_b !== eb) begin
        errors++;
        $display("FAIL rnd_fwd cyc=%0d got=%0d/%0d want=%0d/%0d", n,
                 fwd_a, fwd_b, ea, eb);
      end
      checks++;
      if (stall_cnt !== CW'(sat(m_stall)) ||
          flush_cnt !== CW'(sat(m_flush))) begin
        errors++;
        $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", n,
                 stall_cnt, flush_cnt, sat(m_stall), sat(m_flush));
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rs1_d  = '0;
    rs2_d  = '0;
    rd_d   = '0;
    rw_d   = 1'b0;
    rsrc_d = '0;
    pc_e   = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_x0();
    test_double_match();
    test_branch_lu();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RV64I/Zba core. It sits beside the decode stage and tracks the destination tags of instructions in flight through Execute, Memory and Writeback in its own shadow tag pipeline. From those tags it drives the forwarding selects for the Execute ALU operands, the load-use stall and bubble, and the flushes for taken branches and jumps. It also keeps saturating performance counters for stalls and flushes.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock; one clock domain; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1_D  in  5  rs1 field of the instruction in Decode.
- Rs2_D  in  5  rs2 field of the instruction in Decode.
- Rd_D  in  5  rd field of the instruction in Decode.
- RegWrite_D  in  1  Decode instruction writes rd.
- ResultSrc_D  in  2  Decode result source; RESULTSRC_LOAD marks a load.
- PCSrc_E  in  1  branch taken or jump resolved in Execute.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold IF/ID register.
- Flush_D  out  1  clear IF/ID register to a bubble.
- Flush_E  out  1  clear ID/EX register to a bubble.
- ForwardA_E  out  2  operand A select: FWD_NONE, FWD_WB or FWD_MEM.
- ForwardB_E  out  2  operand B select, same encoding as ForwardA_E.
- StallCnt  out  CNT_W  number of load-use stall cycles.
- FlushCnt  out  CNT_W  number of control flushes.

## Operation
- Shadow tag per stage: rs1, rs2, rd, regwrite, isload. The tag sets are E, M and W.
- Tag E update:
  - Flush_E=1: load a zero bubble.
  - Otherwise: load the Decode fields. isload = (ResultSrc_D == RESULTSRC_LOAD).
- Tag M loads tag E every cycle. Tag W loads tag M every cycle.
- Forwarding for ForwardA_E (ForwardB_E is identical using rs2_e):
  - FWD_MEM if regwrite_m, rd_m≠0 and rd_m==rs1_e.
  - Else FWD_WB if regwrite_w, rd_w≠0 and rd_w==rs1_e.
  - Else FWD_NONE.
  - Memory stage wins over Writeback when both match.
- Load-use condition lw = isload_e, rd_e≠0 and (rd_e==Rs1_D or rd_e==Rs2_D). Both source fields are compared regardless of instruction format; the extra conservative stall is accepted.
- Control flush cf = PCSrc_E.
- Outputs:
  - Stall_F = Stall_D = lw & ~cf.
  - Flush_D = cf.
  - Flush_E = lw | cf.
- Simultaneous lw and cf: the flush wins, stalls stay deasserted, and the Decode instruction is discarded.
- x0 never forwards and never stalls.
- Writeback-to-Decode same-cycle read-after-write is resolved by the register file, not by this block.
- Counters:
  - StallCnt += 1 on each cycle with Stall_D=1.
  - FlushCnt += 1 on each cycle with Flush_D=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Forwarding, stall and flush outputs are combinational from the registered tags plus the current Decode fields and PCSrc_E. There is zero-cycle latency to the pipeline registers they control.
- Tags advance on every rising clk edge. There is no enable: the Memory and Writeback stages never stall in this core.
- A load followed immediately by a dependent instruction gives exactly one stall cycle. In the next cycle the load is in M with isload, and forwarding of load data is FWD_WB one cycle later: the load result reaches the ALU from Writeback.
- While rst=1:
  - All tags clear to zero at the edge.
  - All outputs are forced to 0: Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E.
  - Counters clear to 0.
- The first cycle after rst falls behaves as an empty pipeline.
- Reset mid-operation discards all tags. No stall or flush persists across reset.

## Structure
- pipeline_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RESULTSRC_LOAD=2'b01.
  - The hazard_tag_t struct {rs1, rs2, rd, regwrite, isload}.
- Sub-module hazard_tag_stage: one tag register with synchronous reset and a flush-to-bubble input. It is instantiated three times: E, M and W; M and W tie the flush input low.
- The counters are inline in hazard_unit; do not split them into a separate module.

## Test plan
- Back-to-back ALU dependence: `add x5,x1,x2` then `sub x6,x5,x3`. In the sub's Execute cycle ForwardA_E=FWD_MEM. With one unrelated instruction in between, ForwardA_E=FWD_WB. No stalls occur.
- Load-use: `ld x7,0(x1)` then `add x8,x7,x7`.
  - Exactly one cycle with Stall_F=Stall_D=Flush_E=1.
  - Then the add's Execute cycle shows ForwardA_E=ForwardB_E=FWD_WB.
  - StallCnt increments by 1.
- x0 destination: `addi x0,x0,1` then `add x9,x0,x0`. Forwards stay FWD_NONE. `ld x0` followed by a use of x0 produces no stall.
- Double match: x5 written by both the M-stage and W-stage instructions, with the Execute instruction reading x5. ForwardA_E=FWD_MEM.
- Taken branch with load-use in the same cycle: PCSrc_E=1 while lw=1.
  - Flush_D=Flush_E=1 and Stall_F=Stall_D=0.
  - FlushCnt +1, StallCnt unchanged.
  - The next tag E is a bubble.
- Reset and saturation:
  - Assert rst mid-stream: all outputs go to 0 while rst=1, and the first post-reset dependent pair forwards only from post-reset instructions.
  - With CNT_W=4, 20 stall cycles leave StallCnt=15.
